ms_dbio_cpu_ctrl: RTL and testbench
===================================

Name: ms_dbio_cpu_ctrl

Overview:
- DBIO responder (slave) that receives debug-bus commands from a DBIO initiator (e.g. the boot/test FSM) and drives the CPU control lines: reset, run, single-step, halt.
- Decodes a command word at CBaseAddr and returns a status word at CBaseAddr+1.
- Sits between the DBIO bus fabric and the CPU core. Its MISO output is zero when idle, so it can be OR-combined with other responders.

Parameters:
- CBaseAddr, 12'h000, command register address; status is read at CBaseAddr+1.
- CRstLen, 4, number of enabled clock cycles ACpuReset is held per reset (1..15).

Ports:
- AClkH  in  1  system clock.
- AResetH  in  1  synchronous, active-high reset.
- AClkHEn  in  1  clock enable; no state changes when 0.
- ADbioAddr  in  12  transaction address.
- ADbioMosi  in  64  write data; command is bits [15:0].
- ADbioMosiIdx  in  4  valid MOSI byte count; 0 means no write.
- ADbioMisoIdx  in  4  requested MISO byte count; 0 means no read.
- ADbioMosi1st  in  1  first segment of a write; single-segment transfers here, ignored except when qualifying a write.
- ADbioMiso1st  in  1  first segment of a read; same use, qualifying a read.
- ADbioMiso  out  64  read data; valid one cycle after the read request, otherwise 0.
- ADbioMisoVld  out  1  one-cycle strobe accompanying ADbioMiso.
- ACpuReset  out  1  CPU reset, active high.
- ACpuRun  out  1  CPU free-run enable.
- ACpuStep  out  1  single-step request, level, held until acknowledged.
- ACpuStepDone  in  1  CPU step acknowledge, one-cycle pulse.
- ACpuHalted  in  1  CPU reports pipeline idle.
- ACpuIp  in  32  current CPU instruction pointer (status only).

Behaviour:
- Interface: one clock, AClkH; reset is synchronous and active-high (AResetH).
- All state updates are qualified by AClkHEn. AResetH acts regardless of AClkHEn.
- Reset values: state=StReset, reset counter=CRstLen-1, pending-run=0, sticky error=0, ACpuReset=1, ACpuRun=0, ACpuStep=0, ADbioMiso=0, ADbioMisoVld=0.
- Write decode: Wr = (ADbioAddr==CBaseAddr) & (ADbioMosiIdx!=0).
- Command word C=ADbioMosi[15:0]. The command is taken only if C[0]=1; otherwise the write is ignored.
- Command bits: C[1] reset, C[2] run, C[3] step, C[4] halt.
- Command priority in one word: reset > halt > step > run. Lower-priority bits in the same word are dropped, with one exception: reset+run (C=0x0007) sets pending-run.
- Read decode: Rd = (ADbioAddr==CBaseAddr+1) & (ADbioMisoIdx!=0).
- Read response, next cycle: ADbioMiso = {ACpuIp, 16'h0, status}, ADbioMisoVld=1.
- Status bits: [2:0] state code, [3] pending-run, [4] ACpuHalted, [5] sticky error. Upper status bits are 0.
- The sticky error is cleared by the read that returns it. If a new error occurs in that same cycle, the new error wins.
- Other addresses produce no response, and ADbioMiso stays 0.
- State codes: StReset=0, StHalt=1, StRun=2, StStep=3, StHaltReq=4.
- StReset:
  - ACpuReset=1; counter decrements each enabled cycle.
  - At counter 0: go to StRun if pending-run (and clear it), else StHalt.
  - A run command in StReset sets pending-run.
  - A reset command in StReset reloads the counter.
- StHalt: ACpuRun=0.
  - reset → StReset (counter reload).
  - step → StStep.
  - run → StRun.
  - halt → no-op.
- StRun: ACpuRun=1.
  - halt → StHaltReq.
  - reset → StReset.
  - run → no-op.
  - step → ignored, sets sticky error.
- StStep: ACpuStep=1, ACpuRun=0.
  - ACpuStepDone → StHalt; ACpuStep drops in the same cycle as the transition.
  - reset → StReset, which aborts the step.
  - Other commands → ignored, set sticky error.
- StHaltReq: ACpuRun=0.
  - ACpuHalted=1 → StHalt.
  - reset → StReset.
  - Other commands → sticky error.
- Outputs are registered and decoded from state, with zero latency from the state register.
- A command takes effect on outputs one enabled cycle after the write cycle.
- A write and a read on the same cycle (different addresses) are both serviced. The read returns the pre-write state.
- AResetH during any operation, including a step, forces StReset and restarts the CRstLen hold.

Test Plan:
- Release reset, no writes → ACpuReset=1 for exactly 4 cycles, then state=1 (StHalt), ACpuRun=0.
- Write 0x0003 at 0x000, then 0x0005 next cycle → StReset for 4 cycles with pending-run=1, then ACpuRun=1. Status read returns status[3:0]=2.
- In StHalt, write 0x0009 → ACpuStep=1 until ACpuStepDone pulses, then state=1. ACpuRun stays 0 throughout.
- In StRun, write 0x0011 with ACpuHalted delayed 3 cycles → ACpuRun=0 immediately, state=4 for 3 cycles, then state=1.
- In StRun, write 0x0009 → state stays 2. Status read shows bit5=1; a second read shows bit5=0.
- Read at 0x001 with ACpuIp=0x12345678 → next cycle ADbioMisoVld=1 and ADbioMiso[63:32]=0x12345678. Read at 0x002 → ADbioMiso=0, ADbioMisoVld=0.

Source files
------------

// File: rtl/ms_dbio_cpu_ctrl.sv
// rtl/ms_dbio_cpu_ctrl.sv - DBIO responder driving CPU reset/run/step/halt control lines
module ms_dbio_cpu_ctrl #(
  parameter logic [11:0] CBaseAddr = 12'h000,
  parameter int          CRstLen   = 4
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [11:0] ADbioAddr,
  input  logic [63:0] ADbioMosi,
  input  logic [3:0]  ADbioMosiIdx,
  input  logic [3:0]  ADbioMisoIdx,
  input  logic        ADbioMosi1st,
  input  logic        ADbioMiso1st,
  output logic [63:0] ADbioMiso,
  output logic        ADbioMisoVld,
  output logic        ACpuReset,
  output logic        ACpuRun,
  output logic        ACpuStep,
  input  logic        ACpuStepDone,
  input  logic        ACpuHalted,
  input  logic [31:0] ACpuIp
);

  typedef enum logic [2:0] {
    StReset   = 3'd0,
    StHalt    = 3'd1,
    StRun     = 3'd2,
    StStep    = 3'd3,
    StHaltReq = 3'd4
  } stateT;

  localparam logic [3:0] CRstLoad = 4'(CRstLen - 1);

  stateT       state;
  stateT       stateNxt;
  logic [3:0]  rstCnt;
  logic [3:0]  rstCntNxt;
  logic        pendRun;
  logic        pendRunNxt;
  logic        stickyErr;
  logic        stickyErrNxt;
  logic        newErr;

  logic [15:0] cmd;
  logic        wr;
  logic        rd;
  logic        cmdVld;
  logic        cmdRst;
  logic        cmdHalt;
  logic        cmdStep;
  logic        cmdRun;
  logic        cmdRstRun;
  logic        cmdNonRst;
  logic [15:0] status;

  // Segment flags and upper write data carry no meaning for single-word commands.
  logic unusedBits;
  assign unusedBits = ^{ADbioMosi[63:16], ADbioMosi1st, ADbioMiso1st};

  assign cmd = ADbioMosi[15:0];
  assign wr  = (ADbioAddr == CBaseAddr) && (ADbioMosiIdx != 4'd0);
  assign rd  = (ADbioAddr == (CBaseAddr + 12'd1)) && (ADbioMisoIdx != 4'd0);

  // One command per word: reset > halt > step > run; lower bits are dropped.
  assign cmdVld    = wr & cmd[0];
  assign cmdRst    = cmdVld & cmd[1];
  assign cmdHalt   = cmdVld & ~cmd[1] & cmd[4];
  assign cmdStep   = cmdVld & ~cmd[1] & ~cmd[4] & cmd[3];
  assign cmdRun    = cmdVld & ~cmd[1] & ~cmd[4] & ~cmd[3] & cmd[2];
  assign cmdRstRun = cmdRst & cmd[2];
  assign cmdNonRst = cmdHalt | cmdStep | cmdRun;

  assign status = {10'd0, stickyErr, ACpuHalted, pendRun, state};

  // CPU control lines decode straight from the state register.
  assign ACpuReset = (state == StReset);
  assign ACpuRun   = (state == StRun);
  assign ACpuStep  = (state == StStep);

  // Next-state, reset counter, pending-run and sticky error.
  always_comb begin
    stateNxt   = state;
    rstCntNxt  = rstCnt;
    pendRunNxt = pendRun;
    newErr     = 1'b0;
    case (state)
      StReset: begin
        if (rstCnt == 4'd0) begin
          if (pendRun | cmdRun) begin
            stateNxt   = StRun;
            pendRunNxt = 1'b0;
          end else begin
            stateNxt = StHalt;
          end
        end else begin
          rstCntNxt  = rstCnt - 4'd1;
          pendRunNxt = pendRun | cmdRun;
        end
      end
      StHalt: begin
        if (cmdStep) begin
          stateNxt = StStep;
        end else if (cmdRun) begin
          stateNxt = StRun;
        end
      end
      StRun: begin
        if (cmdHalt) begin
          stateNxt = StHaltReq;
        end else if (cmdStep) begin
          newErr = 1'b1;
        end
      end
      StStep: begin
        if (ACpuStepDone) begin
          stateNxt = StHalt;
        end
        newErr = cmdNonRst;
      end
      StHaltReq: begin
        if (ACpuHalted) begin
          stateNxt = StHalt;
        end
        newErr = cmdNonRst;
      end
      default: begin
        stateNxt  = StReset;
        rstCntNxt = CRstLoad;
      end
    endcase
    // A reset command wins from every state and restarts the hold period.
    if (cmdRst) begin
      stateNxt   = StReset;
      rstCntNxt  = CRstLoad;
      pendRunNxt = pendRun | cmdRstRun;
    end
    // The read that returns the error clears it unless a new one lands now.
    stickyErrNxt = newErr | (stickyErr & ~rd);
  end

  // Register state and the one-cycle-delayed read response.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state        <= StReset;
      rstCnt       <= CRstLoad;
      pendRun      <= 1'b0;
      stickyErr    <= 1'b0;
      ADbioMiso    <= 64'h0;
      ADbioMisoVld <= 1'b0;
    end else if (AClkHEn) begin
      state        <= stateNxt;
      rstCnt       <= rstCntNxt;
      pendRun      <= pendRunNxt;
      stickyErr    <= stickyErrNxt;
      ADbioMisoVld <= rd;
      ADbioMiso    <= rd ? {ACpuIp, 16'h0, status} : 64'h0;
    end
  end

endmodule

// File: tb/tb_ms_dbio_cpu_ctrl.sv
// tb/tb_ms_dbio_cpu_ctrl.sv - scoreboard bench for ms_dbio_cpu_ctrl
module tb_ms_dbio_cpu_ctrl;

  logic        AClkH = 1'b0;
  logic        AResetH;
  logic        AClkHEn;
  logic [11:0] ADbioAddr;
  logic [63:0] ADbioMosi;
  logic [3:0]  ADbioMosiIdx;
  logic [3:0]  ADbioMisoIdx;
  logic        ADbioMosi1st;
  logic        ADbioMiso1st;
  logic [63:0] ADbioMiso;
  logic        ADbioMisoVld;
  logic        ACpuReset;
  logic        ACpuRun;
  logic        ACpuStep;
  logic        ACpuStepDone;
  logic        ACpuHalted;
  logic [31:0] ACpuIp;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] expQ[$];
  logic [63:0] monExp;

  ms_dbio_cpu_ctrl #(.CBaseAddr(12'h000), .CRstLen(4)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .ADbioAddr(ADbioAddr), .ADbioMosi(ADbioMosi),
    .ADbioMosiIdx(ADbioMosiIdx), .ADbioMisoIdx(ADbioMisoIdx),
    .ADbioMosi1st(ADbioMosi1st), .ADbioMiso1st(ADbioMiso1st),
    .ADbioMiso(ADbioMiso), .ADbioMisoVld(ADbioMisoVld),
    .ACpuReset(ACpuReset), .ACpuRun(ACpuRun), .ACpuStep(ACpuStep),
    .ACpuStepDone(ACpuStepDone), .ACpuHalted(ACpuHalted), .ACpuIp(ACpuIp)
  );

  always #5 AClkH = ~AClkH;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic wrCmd(input logic [15:0] c);
    ADbioAddr    = 12'h000;
    ADbioMosi    = {48'hDEAD_BEEF_0000, c};
    ADbioMosiIdx = 4'd2;
    ADbioMosi1st = 1'b1;
    tick();
    ADbioMosiIdx = 4'd0;
    ADbioMosi1st = 1'b0;
    ADbioMosi    = 64'h0;
  endtask

  task automatic rdStat(input logic [15:0] st);
    ADbioAddr    = 12'h001;
    ADbioMisoIdx = 4'd8;
    ADbioMiso1st = 1'b1;
    expQ.push_back({ACpuIp, 16'h0, st});
    tick();
    ADbioMisoIdx = 4'd0;
    ADbioMiso1st = 1'b0;
  endtask

  task automatic countReset(input int limit, output int n);
    n = 0;
    while (ACpuReset && n < limit) begin
      n++;
      tick();
    end
  endtask

  // Monitor: every response strobe pops one expected word; idle data must be zero.
  always @(negedge AClkH) begin
    if (ADbioMisoVld === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_vld: got vld=1 data=%h expected no response", ADbioMiso);
      end else begin
        monExp = expQ.pop_front();
        check("miso_data", ADbioMiso, monExp);
      end
    end else if (ADbioMisoVld === 1'b0) begin
      check("miso_idle_zero", ADbioMiso, 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    AResetH      = 1'b1;
    AClkHEn      = 1'b1;
    ADbioAddr    = 12'h000;
    ADbioMosi    = 64'h0;
    ADbioMosiIdx = 4'd0;
    ADbioMisoIdx = 4'd0;
    ADbioMosi1st = 1'b0;
    ADbioMiso1st = 1'b0;
    ACpuStepDone = 1'b0;
    ACpuHalted   = 1'b0;
    ACpuIp       = 32'hCAFE_0001;
    repeat (3) tick();

    check("rst_cpu_reset", 64'(ACpuReset), 64'd1);
    check("rst_cpu_run", 64'(ACpuRun), 64'd0);
    check("rst_cpu_step", 64'(ACpuStep), 64'd0);
    check("rst_miso_vld", 64'(ADbioMisoVld), 64'd0);

    // Reset release: hold for CRstLen cycles, then halt.
    AResetH = 1'b0;
    countReset(20, n);
    check("rst_hold_cycles", 64'(n), 64'd4);
    check("halt_run_low", 64'(ACpuRun), 64'd0);
    rdStat(16'h0001);

    // Reset command then run while in reset: pending-run, then free-run.
    wrCmd(16'h0003);
    wrCmd(16'h0005);
    check("rstcmd_cpu_reset", 64'(ACpuReset), 64'd1);
    rdStat(16'h0008);
    countReset(20, n);
    check("rstcmd_hold_rest", 64'(n), 64'd2);
    check("pend_run_high", 64'(ACpuRun), 64'd1);
    rdStat(16'h0002);

    // Ignored writes: C[0]=0, wrong address, zero byte count; zero-count read.
    wrCmd(16'h0010);
    ADbioAddr = 12'h005; ADbioMosi = 64'h11; ADbioMosiIdx = 4'd2;
    tick();
    ADbioAddr = 12'h000; ADbioMosiIdx = 4'd0;
    tick();
    ADbioAddr = 12'h001; ADbioMisoIdx = 4'd0;
    tick();
    check("ignored_run_high", 64'(ACpuRun), 64'd1);
    rdStat(16'h0002);

    // Halt request with an illegal run during the wait.
    wrCmd(16'h0011);
    check("haltreq_run_off", 64'(ACpuRun), 64'd0);
    rdStat(16'h0004);
    wrCmd(16'h0005);
    ACpuHalted = 1'b1;
    rdStat(16'h0034);
    rdStat(16'h0011);
    ACpuHalted = 1'b0;
    check("halted_run_low", 64'(ACpuRun), 64'd0);

    // Single step with an illegal run while stepping.
    wrCmd(16'h0009);
    check("step_high", 64'(ACpuStep), 64'd1);
    check("step_run_low", 64'(ACpuRun), 64'd0);
    wrCmd(16'h0005);
    check("step_held", 64'(ACpuStep), 64'd1);
    rdStat(16'h0023);
    ACpuStepDone = 1'b1;
    tick();
    ACpuStepDone = 1'b0;
    check("step_done_drop", 64'(ACpuStep), 64'd0);
    check("step_done_run_low", 64'(ACpuRun), 64'd0);
    rdStat(16'h0001);

    // Step in run is an error; run in run is a no-op; error clears on read.
    wrCmd(16'h0005);
    check("run_high", 64'(ACpuRun), 64'd1);
    wrCmd(16'h0009);
    wrCmd(16'h0005);
    check("run_stays", 64'(ACpuRun), 64'd1);
    rdStat(16'h0022);
    rdStat(16'h0002);

    // Priority: halt beats step and run in one word.
    wrCmd(16'h001D);
    rdStat(16'h0004);
    ACpuHalted = 1'b1;
    tick();
    ACpuHalted = 1'b0;
    rdStat(16'h0001);

    // Reset+run in a single word.
    wrCmd(16'h0007);
    rdStat(16'h0008);
    countReset(20, n);
    check("rstrun_hold_rest", 64'(n), 64'd3);
    check("rstrun_run_high", 64'(ACpuRun), 64'd1);

    // Instruction pointer in the upper half; non-decoded read address.
    ACpuIp = 32'h1234_5678;
    rdStat(16'h0002);
    check("ip_upper", {32'h0, ADbioMiso[63:32]}, 64'h1234_5678);
    ADbioAddr = 12'h002; ADbioMisoIdx = 4'd8;
    tick();
    ADbioMisoIdx = 4'd0;
    check("bad_addr_vld", 64'(ADbioMisoVld), 64'd0);
    check("bad_addr_miso", ADbioMiso, 64'h0);

    // Hardware reset during a step, with clock enable low for part of the hold.
    wrCmd(16'h0011);
    ACpuHalted = 1'b1;
    tick();
    ACpuHalted = 1'b0;
    wrCmd(16'h0009);
    check("step2_high", 64'(ACpuStep), 64'd1);
    AResetH = 1'b1;
    tick();
    check("hwrst_step_abort", 64'(ACpuStep), 64'd0);
    check("hwrst_cpu_reset", 64'(ACpuReset), 64'd1);
    AResetH = 1'b0;
    AClkHEn = 1'b0;
    tick();
    wrCmd(16'h0005);
    tick();
    check("en_low_reset_held", 64'(ACpuReset), 64'd1);
    AClkHEn = 1'b1;
    countReset(20, n);
    check("en_hold_cycles", 64'(n), 64'd4);
    rdStat(16'h0001);

    repeat (3) tick();
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
